// File: rtl/stream_mux_pkg.sv
// Shared types and default sizes for the round-robin stream multiplexer.
package stream_mux_pkg;

   typedef enum logic {
      MODE_FIXED = 1'b0,
      MODE_RR    = 1'b1
   } mux_mode_e;

   localparam int NCH_DEF = 8;
   localparam int W_DEF   = 8;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, wrapping mod NCH.
// Zero latency; the caller owns the pointer register and any backpressure gating.
module rr_arbiter #(
   parameter  int NCH  = 8,
   localparam int SELW = $clog2(NCH)
) (
   input  logic [NCH-1:0]  req,
   input  logic [SELW-1:0] ptr,
   output logic [NCH-1:0]  grant_oh,
   output logic [SELW-1:0] grant_idx,
   output logic            any
);

   int unsigned     sum;
   logic [SELW-1:0] pos;

   always_comb begin
      grant_oh  = '0;
      grant_idx = '0;
      any       = 1'b0;
      sum       = 0;
      pos       = '0;
      for (int k = 0; k < NCH; k++) begin
         // ptr is always < NCH, so a single subtraction performs the wrap.
         sum = int'(ptr) + k;
         if (sum >= NCH) sum = sum - NCH;
         pos = SELW'(sum);
         if (!any && req[pos]) begin
            any           = 1'b1;
            grant_oh[pos] = 1'b1;
            grant_idx     = pos;
         end
      end
   end

endmodule

// File: rtl/stream_mux_rr.sv
// N-channel word mux, fixed-select or round-robin, registered output: 1-cycle latency, in_ready=0 while a beat is held.
// STREAM_MUX_LAST_LOCK_EN adds in_last/out_last and holds the RR grant until a packet's last beat.
module stream_mux_rr
   import stream_mux_pkg::*;
#(
   parameter  int NCH  = NCH_DEF,
   parameter  int W    = W_DEF,
   localparam int SELW = $clog2(NCH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [NCH*W-1:0] in_data,
   input  logic [NCH-1:0]   in_valid,
   output logic [NCH-1:0]   in_ready,
`ifdef STREAM_MUX_LAST_LOCK_EN
   input  logic [NCH-1:0]   in_last,
   output logic             out_last,
`endif
   input  logic             mode,
   input  logic [SELW-1:0]  sel,
   output logic [W-1:0]     out_data,
   output logic [SELW-1:0]  out_ch,
   output logic             out_valid,
   input  logic             out_ready
);

   mux_mode_e       mode_e;
   logic            load;
   logic            push;
   logic [SELW-1:0] rr_ptr;
   logic [NCH-1:0]  rr_req;
   logic [NCH-1:0]  arb_oh;
   logic [SELW-1:0] arb_idx;
   logic            arb_any;
   logic [NCH-1:0]  fix_oh;
   logic [NCH-1:0]  gnt_oh;
   logic [SELW-1:0] gnt_idx;
   logic            gnt_vld;
   logic [W-1:0]    gnt_word;
   logic [SELW-1:0] next_ptr;
`ifdef STREAM_MUX_LAST_LOCK_EN
   logic            lock_vld;
   logic [SELW-1:0] lock_ch;
   logic            gnt_last;
`endif

   assign mode_e = mux_mode_e'(mode);
   assign load   = !out_valid || out_ready;

   always_comb begin
      rr_req = in_valid;
`ifdef STREAM_MUX_LAST_LOCK_EN
      // A locked channel stalls the output rather than yielding to others.
      if (lock_vld) rr_req = in_valid & (NCH'(1) << lock_ch);
`endif
   end

   rr_arbiter #(.NCH(NCH)) u_arb (
      .req       (rr_req),
      .ptr       (rr_ptr),
      .grant_oh  (arb_oh),
      .grant_idx (arb_idx),
      .any       (arb_any)
   );

   always_comb begin
      fix_oh = '0;
      for (int i = 0; i < NCH; i++) begin
         if (sel == SELW'(i)) fix_oh[i] = in_valid[i];
      end
      if (mode_e == MODE_RR) begin
         gnt_oh  = arb_oh;
         gnt_idx = arb_idx;
         gnt_vld = arb_any;
      end else begin
         gnt_oh  = fix_oh;
         gnt_idx = sel;
         gnt_vld = |fix_oh;
      end
   end

   always_comb begin
      gnt_word = '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
      gnt_last = 1'b0;
`endif
      for (int i = 0; i < NCH; i++) begin
         if (gnt_idx == SELW'(i)) begin
            gnt_word = in_data[i*W +: W];
`ifdef STREAM_MUX_LAST_LOCK_EN
            gnt_last = in_last[i];
`endif
         end
      end
   end

   // No handshake may complete while reset is asserted.
   assign push     = load && gnt_vld && !rst;
   assign in_ready = push ? gnt_oh : '0;
   assign next_ptr = (gnt_idx == SELW'(NCH - 1)) ? '0 : gnt_idx + SELW'(1);

   always_ff @(posedge clk) begin
      if (rst) begin
         out_data  <= '0;
         out_ch    <= '0;
         out_valid <= 1'b0;
         rr_ptr    <= '0;
`ifdef STREAM_MUX_LAST_LOCK_EN
         out_last  <= 1'b0;
         lock_vld  <= 1'b0;
         lock_ch   <= '0;
`endif
      end else if (push) begin
         out_data  <= gnt_word;
         out_ch    <= gnt_idx;
         out_valid <= 1'b1;
`ifdef STREAM_MUX_LAST_LOCK_EN
         out_last  <= gnt_last;
`endif
         if (mode_e == MODE_RR) begin
            rr_ptr <= next_ptr;
`ifdef STREAM_MUX_LAST_LOCK_EN
            lock_vld <= !gnt_last;
            lock_ch  <= gnt_idx;
`endif
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end
   end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Directed bench for stream_mux_rr: an 8-channel instance plus a 5-channel one for out-of-range select.
module tb_stream_mux_rr;

   logic        clk = 1'b0;
   logic        rst;

   logic [63:0] in_data;
   logic [7:0]  in_valid;
   logic [7:0]  in_ready;
   logic        mode;
   logic [2:0]  sel;
   logic [7:0]  out_data;
   logic [2:0]  out_ch;
   logic        out_valid;
   logic        out_ready;

   logic [39:0] in_data5;
   logic [4:0]  in_valid5;
   logic [4:0]  in_ready5;
   logic        mode5;
   logic [2:0]  sel5;
   logic [7:0]  out_data5;
   logic [2:0]  out_ch5;
   logic        out_valid5;
   logic        out_ready5;

`ifdef STREAM_MUX_LAST_LOCK_EN
   logic [7:0]  in_last;
   logic        out_last;
   logic [4:0]  in_last5;
   logic        out_last5;
`endif

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   stream_mux_rr #(.NCH(8), .W(8)) u_dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
`ifdef STREAM_MUX_LAST_LOCK_EN
      .in_last   (in_last),
      .out_last  (out_last),
`endif
      .mode      (mode),
      .sel       (sel),
      .out_data  (out_data),
      .out_ch    (out_ch),
      .out_valid (out_valid),
      .out_ready (out_ready)
   );

   stream_mux_rr #(.NCH(5), .W(8)) u_dut5 (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data5),
      .in_valid  (in_valid5),
      .in_ready  (in_ready5),
`ifdef STREAM_MUX_LAST_LOCK_EN
      .in_last   (in_last5),
      .out_last  (out_last5),
`endif
      .mode      (mode5),
      .sel       (sel5),
      .out_data  (out_data5),
      .out_ch    (out_ch5),
      .out_valid (out_valid5),
      .out_ready (out_ready5)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   initial begin
      rst        = 1'b1;
      mode       = 1'b0;
      sel        = 3'd0;
      in_valid   = 8'h00;
      out_ready  = 1'b0;
      mode5      = 1'b0;
      sel5       = 3'd0;
      in_valid5  = 5'h00;
      out_ready5 = 1'b0;
      for (int i = 0; i < 8; i++) in_data[i*8 +: 8] = 8'hA0 + 8'(i);
      for (int i = 0; i < 5; i++) in_data5[i*8 +: 8] = 8'hB0 + 8'(i);
`ifdef STREAM_MUX_LAST_LOCK_EN
      // Single-beat packets everywhere except the dedicated lock test.
      in_last  = 8'hFF;
      in_last5 = 5'h1F;
`endif

      // Reset state
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", 32'(out_valid), 32'h0);
      chk("rst_data",  32'(out_data),  32'h0);
      chk("rst_ch",    32'(out_ch),    32'h0);
      chk("rst_ready", 32'(in_ready),  32'h0);
      chk("rst_valid5", 32'(out_valid5), 32'h0);
      rst = 1'b0;

      // FIXED mode sweep of sel
      out_ready = 1'b1;
      in_valid  = 8'hFF;
      mode      = 1'b0;
      for (int s = 0; s < 8; s++) begin
         sel = 3'(s);
         settle();
         chk($sformatf("fix_ready_s%0d", s), 32'(in_ready), 32'(8'h01 << s));
         tick();
         chk($sformatf("fix_data_s%0d", s),  32'(out_data),  32'(8'hA0 + s));
         chk($sformatf("fix_ch_s%0d", s),    32'(out_ch),    32'(s));
         chk($sformatf("fix_valid_s%0d", s), 32'(out_valid), 32'h1);
      end

      // RR with all channels valid: 0..7 then wrap to 0, one word per cycle
      mode = 1'b1;
      for (int k = 0; k < 9; k++) begin
         settle();
         chk($sformatf("rr_ready_k%0d", k), 32'(in_ready), 32'(8'h01 << (k % 8)));
         tick();
         chk($sformatf("rr_ch_k%0d", k),   32'(out_ch),   32'(k % 8));
         chk($sformatf("rr_data_k%0d", k), 32'(out_data), 32'(8'hA0 + (k % 8)));
         chk($sformatf("rr_valid_k%0d", k), 32'(out_valid), 32'h1);
      end

      // RR with ch2 and ch5 valid, then ch2 only
      in_valid = 8'h24;
      for (int k = 0; k < 4; k++) begin
         tick();
         chk($sformatf("rr25_ch_k%0d", k), 32'(out_ch), (k % 2 == 0) ? 32'd2 : 32'd5);
      end
      in_valid = 8'h04;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk($sformatf("rr2_ch_k%0d", k), 32'(out_ch), 32'd2);
      end

      // Backpressure: held beat is ch2/A2, rr_ptr is 3
      in_valid  = 8'hFF;
      out_ready = 1'b0;
      settle();
      chk("bp_ready_0", 32'(in_ready), 32'h0);
      for (int k = 0; k < 3; k++) begin
         tick();
         if (k == 0) begin
            mode = 1'b0;
            sel  = 3'd6;
         end
         settle();
         chk($sformatf("bp_ch_k%0d", k),    32'(out_ch),    32'd2);
         chk($sformatf("bp_data_k%0d", k),  32'(out_data),  32'hA2);
         chk($sformatf("bp_valid_k%0d", k), 32'(out_valid), 32'h1);
         chk($sformatf("bp_ready_k%0d", k), 32'(in_ready),  32'h0);
      end
      mode      = 1'b1;
      out_ready = 1'b1;
      settle();
      chk("bp_release_ready", 32'(in_ready), 32'h08);
      tick();
      chk("bp_release_ch",   32'(out_ch),   32'd3);
      chk("bp_release_data", 32'(out_data), 32'hA3);
      in_valid = 8'h00;
      settle();
      chk("pop_ready", 32'(in_ready), 32'h0);
      tick();
      chk("pop_valid", 32'(out_valid), 32'h0);

      // NCH=5: out-of-range select, then reset while holding a beat
      mode5      = 1'b0;
      out_ready5 = 1'b1;
      in_valid5  = 5'h1F;
      sel5       = 3'd4;
      settle();
      chk("n5_ready_s4", 32'(in_ready5), 32'h10);
      tick();
      chk("n5_ch_s4",    32'(out_ch5),    32'd4);
      chk("n5_data_s4",  32'(out_data5),  32'hB4);
      chk("n5_valid_s4", 32'(out_valid5), 32'h1);
      sel5 = 3'd6;
      settle();
      chk("n5_ready_s6", 32'(in_ready5), 32'h0);
      tick();
      chk("n5_valid_s6", 32'(out_valid5), 32'h0);
      sel5 = 3'd1;
      tick();
      chk("n5_valid_s1", 32'(out_valid5), 32'h1);
      chk("n5_ch_s1",    32'(out_ch5),    32'd1);
      rst = 1'b1;
      settle();
      chk("n5_rst_ready", 32'(in_ready5), 32'h0);
      tick();
      chk("n5_rst_valid", 32'(out_valid5), 32'h0);
      chk("n5_rst_data",  32'(out_data5),  32'h0);
      chk("n5_rst_ch",    32'(out_ch5),    32'h0);
      chk("rst2_valid",   32'(out_valid),  32'h0);
      rst = 1'b0;
      in_valid5 = 5'h00;

`ifdef STREAM_MUX_LAST_LOCK_EN
      // Packet lock: ch1 sends 3 beats (one stall) while ch0/ch2 also request
      mode      = 1'b1;
      out_ready = 1'b1;
      in_valid  = 8'h01;
      in_last   = 8'h01;
      tick();
      chk("lk_pre_ch",   32'(out_ch),   32'd0);
      chk("lk_pre_last", 32'(out_last), 32'h1);
      in_valid = 8'h07;
      in_last  = 8'h00;
      settle();
      chk("lk_b1_ready", 32'(in_ready), 32'h02);
      tick();
      chk("lk_b1_ch",   32'(out_ch),   32'd1);
      chk("lk_b1_last", 32'(out_last), 32'h0);
      in_valid = 8'h05;
      settle();
      chk("lk_stall_ready", 32'(in_ready), 32'h0);
      tick();
      chk("lk_stall_valid", 32'(out_valid), 32'h0);
      in_valid = 8'h07;
      settle();
      chk("lk_b2_ready", 32'(in_ready), 32'h02);
      tick();
      chk("lk_b2_ch",   32'(out_ch),   32'd1);
      chk("lk_b2_last", 32'(out_last), 32'h0);
      in_last = 8'h02;
      tick();
      chk("lk_b3_ch",   32'(out_ch),   32'd1);
      chk("lk_b3_last", 32'(out_last), 32'h1);
      in_last = 8'h00;
      settle();
      chk("lk_resume_ready", 32'(in_ready), 32'h04);
      tick();
      chk("lk_resume_ch", 32'(out_ch), 32'd2);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
